// File: rtl/fp_exp_align_pipe.sv
// Two-stage elastic pipeline: compare/swap the operands by exponent, then right-align
// the smaller mantissa with guard, round and sticky bits appended.
module fp_exp_align_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 24
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [EXP_W-1:0]   xe,
   input  logic [MAN_W-1:0]   xm,
   input  logic [EXP_W-1:0]   ye,
   input  logic [MAN_W-1:0]   ym,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [EXP_W-1:0]   out_e,
   output logic [MAN_W-1:0]   out_big_m,
   output logic [MAN_W+2:0]   out_small_m,
   output logic               out_swap,
   output logic [EXP_W-1:0]   out_diff
);

   localparam int EXT_W = MAN_W + 3;

   // Handshake: a transfer happens on a rising edge where valid && ready; data is held
   // stable by the producer while valid && !ready, and ready never depends on valid.

   // stage 1 registers
   logic               r_s1_valid;
   logic [EXP_W-1:0]   r_s1_e;
   logic [MAN_W-1:0]   r_s1_big_m;
   logic [MAN_W-1:0]   r_s1_small_m;
   logic               r_s1_swap;
   logic [EXP_W-1:0]   r_s1_diff;

   // stage 2 registers (drive the outputs)
   logic               r_s2_valid;
   logic [EXP_W-1:0]   r_s2_e;
   logic [MAN_W-1:0]   r_s2_big_m;
   logic [EXT_W-1:0]   r_s2_small_m;
   logic               r_s2_swap;
   logic [EXP_W-1:0]   r_s2_diff;

   logic               w_s2_can_load;
   logic               w_s1_advance;
   logic               w_in_fire;
   logic               w_swap;
   logic [EXP_W-1:0]   w_diff;

   logic [31:0]        w_diff32;
   logic [EXT_W-1:0]   w_ext;
   logic [EXT_W-1:0]   w_shifted;
   logic [EXT_W-1:0]   w_mask;
   logic               w_sticky;
   logic               w_sat;
   logic [EXT_W-1:0]   w_aligned;

   assign w_s2_can_load = !r_s2_valid || out_ready;
   assign w_s1_advance  = r_s1_valid && w_s2_can_load;
   assign in_ready      = !r_s1_valid || w_s1_advance;
   assign w_in_fire     = in_valid && in_ready;

   assign w_swap = (xe < ye);
   assign w_diff = w_swap ? (ye - xe) : (xe - ye);

   // mask selects exactly the bits that fall off the right end during the shift
   assign w_diff32  = 32'(r_s1_diff);
   assign w_ext     = {r_s1_small_m, 3'b000};
   assign w_sat     = (w_diff32 >= 32'(EXT_W));
   assign w_shifted = w_ext >> w_diff32;
   assign w_mask    = ~({EXT_W{1'b1}} << w_diff32);
   assign w_sticky  = |(w_ext & w_mask);

   always_comb begin
      w_aligned = '0;
      if (w_sat) begin
         w_aligned = {{(EXT_W-1){1'b0}}, |r_s1_small_m};
      end else begin
         w_aligned = {w_shifted[EXT_W-1:1], w_shifted[0] | w_sticky};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_valid   <= 1'b0;
         r_s1_e       <= '0;
         r_s1_big_m   <= '0;
         r_s1_small_m <= '0;
         r_s1_swap    <= 1'b0;
         r_s1_diff    <= '0;
      end else begin
         if (in_ready) begin
            r_s1_valid <= in_valid;
         end
         if (w_in_fire) begin
            r_s1_e       <= w_swap ? ye : xe;
            r_s1_big_m   <= w_swap ? ym : xm;
            r_s1_small_m <= w_swap ? xm : ym;
            r_s1_swap    <= w_swap;
            r_s1_diff    <= w_diff;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s2_valid   <= 1'b0;
         r_s2_e       <= '0;
         r_s2_big_m   <= '0;
         r_s2_small_m <= '0;
         r_s2_swap    <= 1'b0;
         r_s2_diff    <= '0;
      end else begin
         if (w_s2_can_load) begin
            r_s2_valid <= r_s1_valid;
         end
         if (w_s1_advance) begin
            r_s2_e       <= r_s1_e;
            r_s2_big_m   <= r_s1_big_m;
            r_s2_small_m <= w_aligned;
            r_s2_swap    <= r_s1_swap;
            r_s2_diff    <= r_s1_diff;
         end
      end
   end

   assign out_valid   = r_s2_valid;
   assign out_e       = r_s2_e;
   assign out_big_m   = r_s2_big_m;
   assign out_small_m = r_s2_small_m;
   assign out_swap    = r_s2_swap;
   assign out_diff    = r_s2_diff;

endmodule

// File: tb/tb_fp_exp_align_pipe.sv
// Bench for fp_exp_align_pipe at EXP_W=4, MAN_W=4: directed cases, backpressure,
// mid-stream reset and randomized traffic against an arithmetic reference model.
module tb_fp_exp_align_pipe;

   localparam int EXP_W = 4;
   localparam int MAN_W = 4;
   localparam int RES_W = EXP_W + MAN_W + (MAN_W + 3) + 1 + EXP_W;

   logic               clk;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic [EXP_W-1:0]   xe;
   logic [MAN_W-1:0]   xm;
   logic [EXP_W-1:0]   ye;
   logic [MAN_W-1:0]   ym;
   logic               out_valid;
   logic               out_ready;
   logic [EXP_W-1:0]   out_e;
   logic [MAN_W-1:0]   out_big_m;
   logic [MAN_W+2:0]   out_small_m;
   logic               out_swap;
   logic [EXP_W-1:0]   out_diff;

   int total = 0;
   int bad   = 0;
   int n_out = 0;
   logic [RES_W-1:0] exp_q[$];

   fp_exp_align_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .xe(xe), .xm(xm), .ye(ye), .ym(ym),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_e(out_e), .out_big_m(out_big_m), .out_small_m(out_small_m),
      .out_swap(out_swap), .out_diff(out_diff)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // reference: integer arithmetic on the exponents and the mantissa scaled by 8
   function automatic logic [RES_W-1:0] model(input int a_e, input int a_m,
                                              input int b_e, input int b_m);
      int swap, diff, big_e, big_m, sm, ext, res;
      swap  = (a_e < b_e) ? 1 : 0;
      diff  = swap ? (b_e - a_e) : (a_e - b_e);
      big_e = swap ? b_e : a_e;
      big_m = swap ? b_m : a_m;
      sm    = swap ? a_m : b_m;
      ext   = sm * 8;
      if (diff >= MAN_W + 3) begin
         res = (sm != 0) ? 1 : 0;
      end else begin
         res = ext / (1 << diff);
         if (ext % (1 << diff) != 0) res = res | 1;
      end
      model = {big_e[EXP_W-1:0], big_m[MAN_W-1:0], res[MAN_W+2:0],
               swap[0], diff[EXP_W-1:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // scoreboard: record accepted pairs, compare every visible output against the queue head
   always @(negedge clk) begin
      if (!reset) begin
         if (in_valid && in_ready) exp_q.push_back(model(xe, xm, ye, ym));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
               check("out_data", 32'({out_e, out_big_m, out_small_m, out_swap, out_diff}),
                     32'(exp_q[0]));
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  n_out++;
               end
            end
         end
      end
   end

   // driver tasks
   task automatic directed(input string name, input int a_e, input int a_m, input int b_e,
                           input int b_m, input int e_e, input int e_bm, input int e_sm,
                           input int e_sw, input int e_df);
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      xe = a_e[EXP_W-1:0]; xm = a_m[MAN_W-1:0];
      ye = b_e[EXP_W-1:0]; ym = b_m[MAN_W-1:0];
      @(negedge clk);
      check({name, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check({name, "_lat1_valid"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      check({name, "_lat2_valid"}, 32'(out_valid), 32'd1);
      check({name, "_e"},      32'(out_e),       32'(e_e));
      check({name, "_big_m"},  32'(out_big_m),   32'(e_bm));
      check({name, "_small"},  32'(out_small_m), 32'(e_sm));
      check({name, "_swap"},   32'(out_swap),    32'(e_sw));
      check({name, "_diff"},   32'(out_diff),    32'(e_df));
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   logic [EXP_W-1:0] bp_e[3];
   logic [MAN_W-1:0] bp_m[3];

   initial begin
      int idx, acc_cnt, n0, n;
      logic acc;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      xe = '0; xm = '0; ye = '0; ym = '0;
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'({out_e, out_big_m, out_small_m, out_swap, out_diff}), 32'd0);
      #11 reset = 1'b0;
      @(posedge clk); #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // pin the reference model on hand-computed cases
      check("model_pin_a", 32'(model(5, 10, 3, 13)), 32'({4'd5, 4'b1010, 7'b0011010, 1'b0, 4'd2}));
      check("model_pin_b", 32'(model(4, 0, 0, 1)), 32'({4'd4, 4'd0, 7'b0000001, 1'b0, 4'd4}));

      directed("basic",  5, 4'b1010, 3, 4'b1101, 5, 4'b1010, 7'b0011010, 0, 2);
      directed("sat",    2, 4'b1011, 9, 4'b1000, 9, 4'b1000, 7'b0000001, 1, 7);
      directed("tie",    6, 4'b0111, 6, 4'b1001, 6, 4'b0111, 7'b1001000, 0, 0);
      directed("sticky", 4, 4'b0000, 0, 4'b0001, 4, 4'b0000, 7'b0000001, 0, 4);
      directed("zero",   4, 4'b0000, 0, 4'b0000, 4, 4'b0000, 7'b0000000, 0, 4);
      directed("d6",     7, 4'b0001, 1, 4'b1100, 7, 4'b0001, 7'b0000001, 0, 6);
      wait_drain("directed");

      // backpressure: three pairs against a stalled output
      for (int i = 0; i < 3; i++) begin
         bp_e[i] = 4'($urandom_range(0, 15));
         bp_m[i] = 4'($urandom_range(8, 15));
      end
      n0 = n_out;
      @(posedge clk); #1;
      out_ready = 1'b0;
      idx = 0; acc_cnt = 0;
      in_valid = 1'b1; xe = bp_e[0]; xm = bp_m[0]; ye = 4'd3; ym = 4'b1111;
      repeat (6) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) begin
            acc_cnt++;
            idx++;
            if (idx < 3) begin xe = bp_e[idx]; xm = bp_m[idx]; end
            else in_valid = 1'b0;
         end
      end
      @(negedge clk);
      check("bp_accepted", 32'(acc_cnt), 32'd2);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      n = 0;
      while (idx < 3 && n < 50) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) begin idx++; in_valid = 1'b0; end
         n++;
      end
      wait_drain("bp");
      check("bp_out_count", 32'(n_out - n0), 32'd3);

      // reset with two entries in flight
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b1; xe = 4'd9; xm = 4'b1001; ye = 4'd2; ym = 4'b1110;
      @(posedge clk); #1;
      xe = 4'd1; ye = 4'd8;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #3;
      reset = 1'b1;
      exp_q.delete();
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_data", 32'({out_e, out_big_m, out_small_m, out_swap, out_diff}), 32'd0);
      @(posedge clk); @(posedge clk); #3;
      reset = 1'b0;
      directed("after_rst", 3, 4'b1000, 1, 4'b1011, 3, 4'b1000, 7'b0010110, 0, 2);
      wait_drain("after_rst");

      // randomized traffic, source holds data until accepted
      in_valid = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (!in_valid || acc) begin
            in_valid = ($urandom_range(0, 9) < 7);
            xe = 4'($urandom_range(0, 15)); xm = 4'($urandom_range(0, 15));
            ye = 4'($urandom_range(0, 15)); ym = 4'($urandom_range(0, 15));
         end
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      n = 0;
      while (in_valid && !acc && n < 20) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain("random");
      @(negedge clk);
      check("final_out_valid", 32'(out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_exp_align_pipe.md
Name: fp_exp_align_pipe

Overview:
- Parametrised, pipelined successor to the combinational exponent-difference generator used in the floating-point adder datapath.
- Takes two unpacked operands (exponent, mantissa with hidden bit) and computes the magnitude of the exponent difference.
- Swaps the operands so the larger exponent leads, then right-shifts the smaller mantissa into alignment with guard, round and sticky bits.
- Two-stage valid/ready elastic pipeline; sits between operand unpack and the mantissa adder.

Parameters:
- EXP_W, 8, exponent width in bits (unsigned, biased).
- MAN_W, 24, mantissa width in bits including the hidden bit.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts the operand pair this cycle.
- xe  input  EXP_W  exponent of X.
- xm  input  MAN_W  mantissa of X.
- ye  input  EXP_W  exponent of Y.
- ym  input  MAN_W  mantissa of Y.
- out_valid  output  1  aligned result present.
- out_ready  input  1  downstream accepts the result.
- out_e  output  EXP_W  larger exponent.
- out_big_m  output  MAN_W  mantissa of the larger-exponent operand.
- out_small_m  output  MAN_W+3  aligned smaller mantissa as {mantissa, G, R, S}.
- out_swap  output  1  high when Xe < Ye, i.e. Y became the big operand.
- out_diff  output  EXP_W  exact |Xe - Ye|, not saturated.

Behaviour:
- Reset (async, active-high): both stage valid flags clear immediately. out_valid=0. All data outputs are 0. in_ready=1 from the first clock edge after reset deasserts. Reset mid-operation discards in-flight entries; no partial result is emitted.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Outputs are registered and stay stable while out_valid && !out_ready.
- Stage 1 (compare/swap), registered:
  - swap = (xe < ye), unsigned compare.
  - diff = swap ? ye-xe : xe-ye, width EXP_W, never negative.
  - big = swap ? Y : X; small = the other operand.
  - Tie (xe == ye): swap=0, diff=0, X is big.
- Stage 2 (align), registered:
  - ext = {small_m, 3'b000}, width MAN_W+3.
  - If diff < MAN_W+3: shifted = ext >> diff, and LSB(result) = LSB(shifted) OR (OR of all bits shifted out).
  - If diff >= MAN_W+3 (saturation): result = {MAN_W+2 zeros, S}, where S = OR of all small_m bits.
  - diff=0: result = ext unchanged.
- Latency: exactly 2 cycles from input transfer to out_valid when there is no backpressure.
- Throughput: 1 per cycle.
- Flow control:
  - Stage 2 loads when empty or emptying this cycle (out_ready).
  - Stage 1 loads when empty or advancing into stage 2.
  - in_ready = !s1_valid || s1_advance. This is combinational from out_ready; no combinational path from in_valid to in_ready.
- Capacity: 2 entries. Under sustained backpressure, in_ready drops after two accepted pairs.
- Entries are never dropped, duplicated or reordered.
- Simultaneous input and output transfer with a full pipeline: both occur in the same cycle; occupancy stays at 2.
- in_valid while in_ready=0: no transfer. The source holds its data.

Test Plan:
- EXP_W=4, MAN_W=4; xe=5, xm=1010, ye=3, ym=1101 -> two cycles later: out_valid=1, out_e=5, out_big_m=1010, out_swap=0, out_diff=2, out_small_m=7'b0011010.
- EXP_W=4, MAN_W=4; xe=2, xm=1011, ye=9, ym=1000 -> out_swap=1, out_e=9, out_big_m=1000, out_diff=7 (saturation), out_small_m=7'b0000001.
- Tie: xe=ye=6, xm=0111, ym=1001 -> out_swap=0, out_diff=0, out_big_m=0111, out_small_m=7'b1001000.
- Sticky-only: xe=4, ye=0, ym=0001 -> shifted-out 1 sets S; out_small_m=7'b0000001. Same with ym=0000 -> 7'b0000000.
- Backpressure: out_ready=0, present 3 back-to-back pairs -> exactly 2 accepted, then in_ready=0. Release out_ready -> all 3 results emerge in order, each once, with data stable while stalled.
- Reset mid-stream: assert reset between edges with 2 entries in flight -> out_valid=0 immediately, outputs 0. After release, a new pair emerges at 2-cycle latency with no stale data.
